// File: rtl/uart_mem_cmd_sequencer_if.sv
// UART byte RX/TX and PSRAM byte-port signals between the command sequencer (master)
// and its environment (slave).
interface uart_mem_cmd_sequencer_if #(
    parameter int ADDR_W = 23
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              busy;
    logic              err;

    modport master (
        input  rx_valid, rx_data, tx_ready, mem_ack, mem_rdata,
        output tx_valid, tx_data, mem_req, mem_we, mem_addr, mem_wdata, busy, err
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, mem_ack, mem_rdata,
        input  tx_valid, tx_data, mem_req, mem_we, mem_addr, mem_wdata, busy, err
    );
endinterface

// File: rtl/uart_mem_cmd_sequencer.sv
// Host-driven memory access: parses OP/A2/A1/A0/LEN[/data] frames from the UART,
// performs byte reads/writes on the PSRAM port and streams data or status bytes back.
module uart_mem_cmd_sequencer #(
    parameter int ADDR_W         = 23,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    uart_mem_cmd_sequencer_if.master bus
);
    localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] OP_W    = 8'h57;
    localparam logic [7:0] OP_R    = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_WDATA,
        S_WR_MEM,
        S_RD_MEM,
        S_RD_TX,
        S_ACK_TX,
        S_ERR_TX
    } state_t;

    state_t            r_state;
    logic              r_isWrite;
    logic [ADDR_W-1:0] r_shift;
    logic [1:0]        r_addrBytes;
    logic [ADDR_W-1:0] r_addr;
    logic [8:0]        r_count;
    logic [TW-1:0]     r_timer;
    logic              r_txValid;
    logic [7:0]        r_txData;
    logic              r_memReq;
    logic              r_memWe;
    logic [7:0]        r_memWdata;
    logic              r_err;

    logic w_overrun;
    logic w_timeout;

    assign w_overrun = bus.rx_valid &&
                       (r_state inside {S_WR_MEM, S_RD_MEM, S_RD_TX, S_ACK_TX, S_ERR_TX});
    assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_isWrite   <= 1'b0;
            r_shift     <= '0;
            r_addrBytes <= '0;
            r_addr      <= '0;
            r_count     <= '0;
            r_timer     <= '0;
            r_txValid   <= 1'b0;
            r_txData    <= '0;
            r_memReq    <= 1'b0;
            r_memWe     <= 1'b0;
            r_memWdata  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_overrun;
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (bus.rx_valid) begin
                        if (bus.rx_data == OP_W || bus.rx_data == OP_R) begin
                            r_isWrite   <= (bus.rx_data == OP_W);
                            r_addrBytes <= '0;
                            r_state     <= S_ADDR;
                        end else begin
                            r_err     <= 1'b1;
                            r_txValid <= 1'b1;
                            r_txData  <= RSP_ERR;
                            r_state   <= S_ERR_TX;
                        end
                    end
                end
                // Only the low ADDR_W bits of the 24-bit frame address are kept.
                S_ADDR: begin
                    if (bus.rx_valid) begin
                        r_shift     <= ADDR_W'({r_shift, bus.rx_data});
                        r_addrBytes <= r_addrBytes + 2'd1;
                        r_timer     <= '0;
                        if (r_addrBytes == 2'd2) begin
                            r_state <= S_LEN;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_LEN: begin
                    if (bus.rx_valid) begin
                        r_addr  <= r_shift;
                        r_count <= (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
                        r_timer <= '0;
                        r_state <= r_isWrite ? S_WDATA : S_RD_MEM;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WDATA: begin
                    if (bus.rx_valid) begin
                        r_memWdata <= bus.rx_data;
                        r_timer    <= '0;
                        r_state    <= S_WR_MEM;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                // Request is raised one cycle after entry and dropped on the ack edge,
                // which guarantees an idle cycle between consecutive requests.
                S_WR_MEM: begin
                    if (!r_memReq) begin
                        r_memReq <= 1'b1;
                        r_memWe  <= 1'b1;
                    end else if (bus.mem_ack) begin
                        r_memReq <= 1'b0;
                        r_memWe  <= 1'b0;
                        r_addr   <= r_addr + 1'b1;
                        r_count  <= r_count - 1'b1;
                        if (r_count == 9'd1) begin
                            r_txValid <= 1'b1;
                            r_txData  <= RSP_ACK;
                            r_state   <= S_ACK_TX;
                        end else begin
                            r_state <= S_WDATA;
                        end
                    end
                end
                S_RD_MEM: begin
                    if (!r_memReq) begin
                        r_memReq <= 1'b1;
                        r_memWe  <= 1'b0;
                    end else if (bus.mem_ack) begin
                        r_memReq  <= 1'b0;
                        r_txData  <= bus.mem_rdata;
                        r_txValid <= 1'b1;
                        r_state   <= S_RD_TX;
                    end
                end
                S_RD_TX: begin
                    if (bus.tx_ready) begin
                        r_txValid <= 1'b0;
                        r_addr    <= r_addr + 1'b1;
                        r_count   <= r_count - 1'b1;
                        r_state   <= (r_count == 9'd1) ? S_IDLE : S_RD_MEM;
                    end
                end
                S_ACK_TX, S_ERR_TX: begin
                    if (bus.tx_ready) begin
                        r_txValid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_valid  = r_txValid;
    assign bus.tx_data   = r_txData;
    assign bus.mem_req   = r_memReq;
    assign bus.mem_we    = r_memWe;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_memWdata;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.err       = r_err;
endmodule

// File: tb/tb_uart_mem_cmd_sequencer.sv
// Directed bench for uart_mem_cmd_sequencer: host frames in, a PSRAM responder model and
// a UART TX sink on the other side, hand-computed expectations throughout.
module tb_uart_mem_cmd_sequencer;
    localparam int ADDR_W = 23;
    localparam int TO     = 40;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wdata;
    } memOp_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic memHold = 1'b0;
    logic txReadyEn = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    int   errCount = 0;

    logic [7:0] tbMem [0:65535];
    logic [7:0] txLog [$];
    memOp_t     memLog [$];

    uart_mem_cmd_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    uart_mem_cmd_sequencer #(
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk(clk),
        .sys_rst_n(rstN),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] patByte(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Contents the memory should hold after the first write frame.
    function automatic logic [7:0] expectedByte(input logic [ADDR_W-1:0] a);
        case (a)
            23'h000010: return 8'hAA;
            23'h000011: return 8'hBB;
            23'h000012: return 8'hCC;
            default:    return patByte(a);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic waitTxCount(input string tag, input int n, input int budget);
        int k = 0;
        while (txLog.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        checkOutput(tag, txLog.size(), n);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " tx_valid"}, bus.tx_valid, 0);
        checkOutput({tag, " mem_req"}, bus.mem_req, 0);
        checkOutput({tag, " mem_we"}, bus.mem_we, 0);
        checkOutput({tag, " mem_addr"}, bus.mem_addr, 0);
        checkOutput({tag, " busy"}, bus.busy, 0);
        checkOutput({tag, " err"}, bus.err, 0);
    endtask

    // PSRAM model: acks any visible request at the next falling edge unless held off.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        for (int i = 0; i < 65536; i++) tbMem[i] = patByte(ADDR_W'(i));
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req && !memHold) begin
                bus.mem_ack = 1'b1;
                if (bus.mem_we) tbMem[bus.mem_addr[15:0]] = bus.mem_wdata;
                else            bus.mem_rdata = tbMem[bus.mem_addr[15:0]];
                memLog.push_back(memOp_t'{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata});
            end
        end
    end

    // UART TX sink: a byte is logged when valid and ready are both high before the edge.
    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.tx_ready = txReadyEn;
            if (bus.tx_valid && bus.tx_ready) txLog.push_back(bus.tx_data);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.err) errCount++;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete, compared %0d", compared);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int errBefore;
        int memBefore;
        int txBefore;
        logic [ADDR_W-1:0] ea;
        logic [7:0] wrData [3];
        wrData[0] = 8'hAA;
        wrData[1] = 8'hBB;
        wrData[2] = 8'hCC;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        checkOutput("reset tx_data", bus.tx_data, 0);
        checkOutput("reset mem_wdata", bus.mem_wdata, 0);
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: write AA BB CC to 0x10..0x12, expect 'K'
        $display("[TB] write frame");
        applyStimulus(8'h57, 4);
        applyStimulus(8'h00, 4);
        applyStimulus(8'h00, 4);
        applyStimulus(8'h10, 4);
        applyStimulus(8'h03, 4);
        for (int i = 0; i < 3; i++) applyStimulus(wrData[i], 6);
        waitTxCount("wr tx count", 1, 50);
        checkOutput("wr reply", txLog[0], 8'h4B);
        checkOutput("wr req count", memLog.size(), 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("wr we", memLog[i].we, 1);
            checkOutput("wr addr", memLog[i].addr, 32'h10 + i);
            checkOutput("wr data", memLog[i].wdata, wrData[i]);
        end
        checkOutput("wr no err", errCount, 0);
        @(negedge clk); #1;
        checkOutput("wr idle", bus.busy, 0);

        // Test 2: read back 0x10..0x12 with latency checks
        $display("[TB] read frame");
        applyStimulus(8'h52, 4);
        applyStimulus(8'h00, 4);
        applyStimulus(8'h00, 4);
        applyStimulus(8'h10, 4);
        applyStimulus(8'h03, 0);
        checkOutput("rd req latency 1", bus.mem_req, 0);
        @(negedge clk);
        checkOutput("rd req latency 2", bus.mem_req, 1);
        @(negedge clk);
        checkOutput("rd ack to tx_valid", bus.tx_valid, 1);
        waitTxCount("rd tx count", 4, 100);
        checkOutput("rd busy before last", bus.busy, 1);
        @(negedge clk); #1;
        checkOutput("rd busy after last", bus.busy, 0);
        checkOutput("rd req count", memLog.size(), 6);
        for (int i = 0; i < 3; i++) begin
            checkOutput("rd we", memLog[3 + i].we, 0);
            checkOutput("rd addr", memLog[3 + i].addr, 32'h10 + i);
            checkOutput("rd data", txLog[1 + i], wrData[i]);
        end

        // Test 3: bad opcode
        $display("[TB] bad opcode");
        errBefore = errCount;
        memBefore = memLog.size();
        applyStimulus(8'h41, 0);
        waitTxCount("badop tx count", 5, 50);
        checkOutput("badop reply", txLog[4], 8'h3F);
        checkOutput("badop err", errCount - errBefore, 1);
        checkOutput("badop no mem", memLog.size(), memBefore);
        @(negedge clk); #1;
        checkOutput("badop idle", bus.busy, 0);

        // Test 4: 256-byte read wrapping from 0x7FFFFF
        $display("[TB] wrapping read");
        memBefore = memLog.size();
        txBefore  = txLog.size();
        applyStimulus(8'h52, 4);
        applyStimulus(8'h7F, 4);
        applyStimulus(8'hFF, 4);
        applyStimulus(8'hFF, 4);
        applyStimulus(8'h00, 0);
        waitTxCount("wrap tx count", txBefore + 256, 256 * 12);
        checkOutput("wrap req count", memLog.size() - memBefore, 256);
        for (int i = 0; i < 256; i++) begin
            ea = 23'h7FFFFF + ADDR_W'(i);
            checkOutput("wrap we", memLog[memBefore + i].we, 0);
            checkOutput("wrap addr", memLog[memBefore + i].addr, ea);
            checkOutput("wrap data", txLog[txBefore + i], expectedByte(ea));
        end
        checkOutput("wrap last addr", memLog[memBefore + 255].addr, 32'hFE);
        @(negedge clk); #1;
        checkOutput("wrap idle", bus.busy, 0);

        // Test 5a: inter-byte timeout after two bytes
        $display("[TB] timeout");
        errBefore = errCount;
        txBefore  = txLog.size();
        applyStimulus(8'h57, 4);
        applyStimulus(8'h00, 0);
        repeat (TO - 1) @(negedge clk);
        #1;
        checkOutput("timeout not early busy", bus.busy, 1);
        checkOutput("timeout not early err", errCount - errBefore, 0);
        @(negedge clk); #1;
        checkOutput("timeout err pulse", bus.err, 1);
        checkOutput("timeout idle", bus.busy, 0);
        repeat (10) @(negedge clk);
        #1;
        checkOutput("timeout err count", errCount - errBefore, 1);
        checkOutput("timeout no tx", txLog.size(), txBefore);

        // Test 5b: overrun byte while the write is stalled
        $display("[TB] overrun");
        memHold   = 1'b1;
        errBefore = errCount;
        memBefore = memLog.size();
        txBefore  = txLog.size();
        applyStimulus(8'h57, 4);
        applyStimulus(8'h00, 4);
        applyStimulus(8'h00, 4);
        applyStimulus(8'h20, 4);
        applyStimulus(8'h01, 4);
        applyStimulus(8'hAB, 0);
        @(negedge clk);
        applyStimulus(8'h99, 0);
        #1;
        checkOutput("overrun err", bus.err, 1);
        checkOutput("overrun req held", bus.mem_req, 1);
        checkOutput("overrun wdata kept", bus.mem_wdata, 8'hAB);
        checkOutput("overrun addr kept", bus.mem_addr, 32'h20);
        memHold = 1'b0;
        waitTxCount("overrun tx count", txBefore + 1, 50);
        checkOutput("overrun reply", txLog[txBefore], 8'h4B);
        checkOutput("overrun req count", memLog.size() - memBefore, 1);
        checkOutput("overrun wr addr", memLog[memBefore].addr, 32'h20);
        checkOutput("overrun wr data", memLog[memBefore].wdata, 8'hAB);
        checkOutput("overrun err count", errCount - errBefore, 1);
        @(negedge clk); #1;

        // Test 6a: reset while a read request is outstanding
        $display("[TB] reset in RD_MEM");
        memHold   = 1'b1;
        memBefore = memLog.size();
        applyStimulus(8'h52, 4);
        applyStimulus(8'h00, 4);
        applyStimulus(8'h00, 4);
        applyStimulus(8'h10, 4);
        applyStimulus(8'h01, 0);
        @(negedge clk); #1;
        checkOutput("rst1 req before", bus.mem_req, 1);
        pulseReset();
        checkAllZero("rst1");
        memHold = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst1 no mem", memLog.size(), memBefore);

        // Test 6b: reset while a read byte waits for tx_ready, then a clean frame
        $display("[TB] reset in RD_TX");
        txReadyEn = 1'b0;
        txBefore  = txLog.size();
        applyStimulus(8'h52, 4);
        applyStimulus(8'h00, 4);
        applyStimulus(8'h00, 4);
        applyStimulus(8'h11, 4);
        applyStimulus(8'h01, 0);
        for (int k = 0; k < 20 && !bus.tx_valid; k++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("rst2 tx_valid before", bus.tx_valid, 1);
        pulseReset();
        checkAllZero("rst2");
        checkOutput("rst2 tx_data", bus.tx_data, 0);
        txReadyEn = 1'b1;
        applyStimulus(8'h52, 4);
        applyStimulus(8'h00, 4);
        applyStimulus(8'h00, 4);
        applyStimulus(8'h12, 4);
        applyStimulus(8'h01, 0);
        waitTxCount("rst2 tx count", txBefore + 1, 50);
        checkOutput("rst2 frame data", txLog[txBefore], 8'hCC);
        @(negedge clk); #1;
        checkOutput("rst2 idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
